// File: rtl/asrv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : asrv32_mem_arbiter
// Description : Round-robin arbiter sharing one stb/ack memory port between
//               the instruction and data requesters, with per-grant timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module asrv32_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // instruction requester
    input  logic        i_inst_stb,
    input  logic [31:0] i_inst_addr,
    output logic        o_inst_ack,
    output logic [31:0] o_inst_rdata,
    output logic        o_inst_err,
    // data requester
    input  logic        i_data_stb,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    input  logic        i_data_wr_en,
    input  logic [3:0]  i_data_wr_mask,
    output logic        o_data_ack,
    output logic [31:0] o_data_rdata,
    output logic        o_data_err,
    // shared memory port
    output logic        o_mem_stb,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wr_en,
    output logic [3:0]  o_mem_wr_mask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_GRANT_INST = 2'd1;
    localparam logic [1:0] c_GRANT_DATA = 2'd2;

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_data_q, last_data_d;

    logic        inst_pend_q, inst_pend_d;
    logic [31:0] inst_pend_addr_q, inst_pend_addr_d;

    logic        data_pend_q, data_pend_d;
    logic [31:0] data_pend_addr_q, data_pend_addr_d;
    logic [31:0] data_pend_wdata_q, data_pend_wdata_d;
    logic        data_pend_wr_en_q, data_pend_wr_en_d;
    logic [3:0]  data_pend_mask_q, data_pend_mask_d;

    logic        mem_stb_q, mem_stb_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [3:0]  mem_mask_q, mem_mask_d;

    logic        inst_ack_q, inst_ack_d;
    logic        inst_err_q, inst_err_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic        data_ack_q, data_ack_d;
    logic        data_err_q, data_err_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic w_inst_req;
    logic w_data_req;
    logic w_grant_inst;
    logic w_grant_data;
    logic w_expired;

    assign w_inst_req = i_inst_stb | inst_pend_q;
    assign w_data_req = i_data_stb | data_pend_q;

    // On a tie the port that did not win last time gets the memory.
    assign w_grant_inst = (state_q == c_IDLE) && w_inst_req && (!w_data_req || last_data_q);
    assign w_grant_data = (state_q == c_IDLE) && w_data_req && !w_grant_inst;
    assign w_expired    = (cnt_q == c_CNT_LAST);

    always_comb begin
        inst_pend_d      = inst_pend_q;
        inst_pend_addr_d = inst_pend_addr_q;
        if (w_grant_inst) begin
            inst_pend_d = 1'b0;
        end else if (i_inst_stb && !inst_pend_q && (state_q != c_GRANT_INST)) begin
            inst_pend_d      = 1'b1;
            inst_pend_addr_d = i_inst_addr;
        end
    end

    always_comb begin
        data_pend_d       = data_pend_q;
        data_pend_addr_d  = data_pend_addr_q;
        data_pend_wdata_d = data_pend_wdata_q;
        data_pend_wr_en_d = data_pend_wr_en_q;
        data_pend_mask_d  = data_pend_mask_q;
        if (w_grant_data) begin
            data_pend_d = 1'b0;
        end else if (i_data_stb && !data_pend_q && (state_q != c_GRANT_DATA)) begin
            data_pend_d       = 1'b1;
            data_pend_addr_d  = i_data_addr;
            data_pend_wdata_d = i_data_wdata;
            data_pend_wr_en_d = i_data_wr_en;
            data_pend_mask_d  = i_data_wr_mask;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_data_d  = last_data_q;
        mem_stb_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_en_d  = mem_wr_en_q;
        mem_mask_d   = mem_mask_q;
        inst_ack_d   = 1'b0;
        inst_err_d   = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_ack_d   = 1'b0;
        data_err_d   = 1'b0;
        data_rdata_d = data_rdata_q;

        case (state_q)
            c_IDLE: begin
                if (w_grant_inst) begin
                    state_d     = c_GRANT_INST;
                    cnt_d       = 8'd0;
                    last_data_d = 1'b0;
                    mem_stb_d   = 1'b1;
                    mem_addr_d  = inst_pend_q ? inst_pend_addr_q : i_inst_addr;
                    mem_wdata_d = 32'd0;
                    mem_wr_en_d = 1'b0;
                    mem_mask_d  = 4'd0;
                end else if (w_grant_data) begin
                    state_d     = c_GRANT_DATA;
                    cnt_d       = 8'd0;
                    last_data_d = 1'b1;
                    mem_stb_d   = 1'b1;
                    mem_addr_d  = data_pend_q ? data_pend_addr_q  : i_data_addr;
                    mem_wdata_d = data_pend_q ? data_pend_wdata_q : i_data_wdata;
                    mem_wr_en_d = data_pend_q ? data_pend_wr_en_q : i_data_wr_en;
                    mem_mask_d  = data_pend_q ? data_pend_mask_q  : i_data_wr_mask;
                end
            end
            c_GRANT_INST: begin
                // A real ack wins over an expiry landing on the same edge.
                if (i_mem_ack) begin
                    state_d      = c_IDLE;
                    inst_ack_d   = 1'b1;
                    inst_rdata_d = i_mem_rdata;
                end else if (w_expired) begin
                    state_d      = c_IDLE;
                    inst_ack_d   = 1'b1;
                    inst_err_d   = 1'b1;
                    inst_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            c_GRANT_DATA: begin
                if (i_mem_ack) begin
                    state_d      = c_IDLE;
                    data_ack_d   = 1'b1;
                    data_rdata_d = i_mem_rdata;
                end else if (w_expired) begin
                    state_d      = c_IDLE;
                    data_ack_d   = 1'b1;
                    data_err_d   = 1'b1;
                    data_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= c_IDLE;
            cnt_q             <= 8'd0;
            last_data_q       <= 1'b1;
            inst_pend_q       <= 1'b0;
            inst_pend_addr_q  <= 32'd0;
            data_pend_q       <= 1'b0;
            data_pend_addr_q  <= 32'd0;
            data_pend_wdata_q <= 32'd0;
            data_pend_wr_en_q <= 1'b0;
            data_pend_mask_q  <= 4'd0;
            mem_stb_q         <= 1'b0;
            mem_addr_q        <= 32'd0;
            mem_wdata_q       <= 32'd0;
            mem_wr_en_q       <= 1'b0;
            mem_mask_q        <= 4'd0;
            inst_ack_q        <= 1'b0;
            inst_err_q        <= 1'b0;
            inst_rdata_q      <= 32'd0;
            data_ack_q        <= 1'b0;
            data_err_q        <= 1'b0;
            data_rdata_q      <= 32'd0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            last_data_q       <= last_data_d;
            inst_pend_q       <= inst_pend_d;
            inst_pend_addr_q  <= inst_pend_addr_d;
            data_pend_q       <= data_pend_d;
            data_pend_addr_q  <= data_pend_addr_d;
            data_pend_wdata_q <= data_pend_wdata_d;
            data_pend_wr_en_q <= data_pend_wr_en_d;
            data_pend_mask_q  <= data_pend_mask_d;
            mem_stb_q         <= mem_stb_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            mem_wr_en_q       <= mem_wr_en_d;
            mem_mask_q        <= mem_mask_d;
            inst_ack_q        <= inst_ack_d;
            inst_err_q        <= inst_err_d;
            inst_rdata_q      <= inst_rdata_d;
            data_ack_q        <= data_ack_d;
            data_err_q        <= data_err_d;
            data_rdata_q      <= data_rdata_d;
        end
    end

    assign o_mem_stb     = mem_stb_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_mem_wr_en   = mem_wr_en_q;
    assign o_mem_wr_mask = mem_mask_q;
    assign o_inst_ack    = inst_ack_q;
    assign o_inst_err    = inst_err_q;
    assign o_inst_rdata  = inst_rdata_q;
    assign o_data_ack    = data_ack_q;
    assign o_data_err    = data_err_q;
    assign o_data_rdata  = data_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_asrv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_asrv32_mem_arbiter
// Description : Directed self-checking bench for asrv32_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asrv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_stb;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        inst_err;
    logic        data_stb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_wr_en;
    logic [3:0]  data_wr_mask;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        mem_stb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt = 0;

    always #5 clk = ~clk;

    asrv32_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_inst_stb    (inst_stb),
        .i_inst_addr   (inst_addr),
        .o_inst_ack    (inst_ack),
        .o_inst_rdata  (inst_rdata),
        .o_inst_err    (inst_err),
        .i_data_stb    (data_stb),
        .i_data_addr   (data_addr),
        .i_data_wdata  (data_wdata),
        .i_data_wr_en  (data_wr_en),
        .i_data_wr_mask(data_wr_mask),
        .o_data_ack    (data_ack),
        .o_data_rdata  (data_rdata),
        .o_data_err    (data_err),
        .o_mem_stb     (mem_stb),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_wr_en   (mem_wr_en),
        .o_mem_wr_mask (mem_wr_mask),
        .i_mem_ack     (mem_ack),
        .i_mem_rdata   (mem_rdata)
    );

    always @(negedge clk) if (mem_stb === 1'b1) stb_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        inst_stb = 1'b0; inst_addr = 32'd0;
        data_stb = 1'b0; data_addr = 32'd0; data_wdata = 32'd0;
        data_wr_en = 1'b0; data_wr_mask = 4'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (mem_stb !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_ctl: stb=%b wr_en=%b want 0 0", mem_stb, mem_wr_en);
        end
        n_tests++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wr_mask !== 4'd0) begin
            n_fail++; $display("FAIL reset_mem_bus: addr=%h wdata=%h mask=%h want 0", mem_addr, mem_wdata, mem_wr_mask);
        end
        n_tests++;
        if ({inst_ack, inst_err, data_ack, data_err} !== 4'b0000 || inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_resp: ack/err=%b%b%b%b rdata=%h/%h want all 0",
                               inst_ack, inst_err, data_ack, data_err, inst_rdata, data_rdata);
        end
    endtask

    task automatic test_single_read();
        stb_cnt = 0;
        inst_stb = 1'b1; inst_addr = 32'h10;
        tick();                                   // E0
        inst_stb = 1'b0;
        n_tests++;
        if (mem_stb !== 1'b1 || mem_addr !== 32'h10 || mem_wr_en !== 1'b0 || mem_wr_mask !== 4'd0) begin
            n_fail++; $display("FAIL read_issue: stb=%b addr=%h wr_en=%b mask=%h want 1 00000010 0 0",
                               mem_stb, mem_addr, mem_wr_en, mem_wr_mask);
        end
        tick();                                   // E1
        n_tests++;
        if (mem_stb !== 1'b0 || inst_ack !== 1'b0) begin
            n_fail++; $display("FAIL read_stb_pulse: stb=%b ack=%b want 0 0", mem_stb, inst_ack);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();                                   // E2
        mem_ack = 1'b0;
        n_tests++;
        if (inst_ack !== 1'b1 || inst_err !== 1'b0 || inst_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_resp: ack=%b err=%b rdata=%h want 1 0 deadbeef", inst_ack, inst_err, inst_rdata);
        end
        tick();                                   // E3
        n_tests++;
        if (inst_ack !== 1'b0 || inst_rdata !== 32'hDEADBEEF || stb_cnt !== 1) begin
            n_fail++; $display("FAIL read_after: ack=%b rdata=%h stbs=%0d want 0 deadbeef 1", inst_ack, inst_rdata, stb_cnt);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        inst_stb = 1'b1; inst_addr = 32'h100;
        data_stb = 1'b1; data_addr = 32'h20; data_wdata = 32'hA5A5A5A5;
        data_wr_en = 1'b1; data_wr_mask = 4'hF;
        tick();                                   // E0: instruction wins first tie
        inst_stb = 1'b0; data_stb = 1'b0;
        data_addr = 32'hFFFFFFFF; data_wdata = 32'h0; data_wr_en = 1'b0; data_wr_mask = 4'h0;
        n_tests++;
        if (mem_stb !== 1'b1 || mem_addr !== 32'h100 || mem_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL tie1_inst: stb=%b addr=%h wr_en=%b want 1 00000100 0", mem_stb, mem_addr, mem_wr_en);
        end
        tick();                                   // E1
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick();                                   // E2
        mem_ack = 1'b0;
        n_tests++;
        if (inst_ack !== 1'b1 || data_ack !== 1'b0 || inst_rdata !== 32'h11111111) begin
            n_fail++; $display("FAIL tie1_inst_ack: iack=%b dack=%b rdata=%h want 1 0 11111111", inst_ack, data_ack, inst_rdata);
        end
        inst_stb = 1'b1; inst_addr = 32'h200;     // ties with the pending data request
        tick();                                   // E3: data wins this tie
        inst_stb = 1'b0;
        n_tests++;
        if (mem_stb !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hA5A5A5A5 ||
            mem_wr_en !== 1'b1 || mem_wr_mask !== 4'hF) begin
            n_fail++; $display("FAIL tie2_data: stb=%b addr=%h wdata=%h wr_en=%b mask=%h want 1 00000020 a5a5a5a5 1 f",
                               mem_stb, mem_addr, mem_wdata, mem_wr_en, mem_wr_mask);
        end
        tick();                                   // E4
        n_tests++;
        if (mem_stb !== 1'b0 || mem_addr !== 32'h20 || mem_wdata !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL tie2_hold: stb=%b addr=%h wdata=%h want 0 00000020 a5a5a5a5", mem_stb, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();                                   // E5
        mem_ack = 1'b0;
        n_tests++;
        if (data_ack !== 1'b1 || data_err !== 1'b0 || data_rdata !== 32'hCAFEF00D || inst_ack !== 1'b0) begin
            n_fail++; $display("FAIL tie2_data_ack: dack=%b derr=%b rdata=%h iack=%b want 1 0 cafef00d 0",
                               data_ack, data_err, data_rdata, inst_ack);
        end
        tick();                                   // E6: pending instruction
        n_tests++;
        if (mem_stb !== 1'b1 || mem_addr !== 32'h200 || mem_wr_en !== 1'b0 || mem_wr_mask !== 4'd0) begin
            n_fail++; $display("FAIL pend_inst_issue: stb=%b addr=%h wr_en=%b mask=%h want 1 00000200 0 0",
                               mem_stb, mem_addr, mem_wr_en, mem_wr_mask);
        end
        tick();                                   // E7
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        tick();                                   // E8
        mem_ack = 1'b0;
        n_tests++;
        if (inst_ack !== 1'b1 || inst_rdata !== 32'h22222222) begin
            n_fail++; $display("FAIL pend_inst_ack: ack=%b rdata=%h want 1 22222222", inst_ack, inst_rdata);
        end
        tick();
    endtask

    task automatic test_mid_grant();
        inst_stb = 1'b1; inst_addr = 32'h300;
        tick();                                   // E0
        inst_stb = 1'b0;
        data_stb = 1'b1; data_addr = 32'h40; data_wdata = 32'h0; data_wr_en = 1'b0; data_wr_mask = 4'h0;
        tick();                                   // E1: data latched pending
        data_stb = 1'b0;
        stb_cnt = 0;
        mem_ack = 1'b1; mem_rdata = 32'h33333333;
        tick();                                   // E2
        mem_ack = 1'b0;
        n_tests++;
        if (inst_ack !== 1'b1 || inst_rdata !== 32'h33333333 || mem_stb !== 1'b0) begin
            n_fail++; $display("FAIL mid_inst_ack: ack=%b rdata=%h stb=%b want 1 33333333 0", inst_ack, inst_rdata, mem_stb);
        end
        tick();                                   // E3
        n_tests++;
        if (mem_stb !== 1'b1 || mem_addr !== 32'h40 || mem_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL mid_data_issue: stb=%b addr=%h wr_en=%b want 1 00000040 0", mem_stb, mem_addr, mem_wr_en);
        end
        tick();                                   // E4
        mem_ack = 1'b1; mem_rdata = 32'h44;
        tick();                                   // E5
        mem_ack = 1'b0;
        n_tests++;
        if (data_ack !== 1'b1 || data_rdata !== 32'h44) begin
            n_fail++; $display("FAIL mid_data_ack: ack=%b rdata=%h want 1 00000044", data_ack, data_rdata);
        end
        tick(); tick();
        n_tests++;
        if (stb_cnt !== 1 || data_ack !== 1'b0) begin
            n_fail++; $display("FAIL mid_stb_count: stbs=%0d ack=%b want 1 0", stb_cnt, data_ack);
        end
    endtask

    task automatic test_timeout();
        data_stb = 1'b1; data_addr = 32'h50; data_wr_en = 1'b0; data_wr_mask = 4'h0;
        tick();                                   // grant edge
        data_stb = 1'b0;
        tick(); tick(); tick();                   // 3 edges without ack
        n_tests++;
        if (data_ack !== 1'b0 || mem_addr !== 32'h50) begin
            n_fail++; $display("FAIL to_early: ack=%b addr=%h want 0 00000050", data_ack, mem_addr);
        end
        tick();                                   // 4th edge: expiry
        n_tests++;
        if (data_ack !== 1'b1 || data_err !== 1'b1 || data_rdata !== 32'd0) begin
            n_fail++; $display("FAIL to_resp: ack=%b err=%b rdata=%h want 1 1 0", data_ack, data_err, data_rdata);
        end
        tick();
        n_tests++;
        if (data_ack !== 1'b0 || data_err !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse: ack=%b err=%b want 0 0", data_ack, data_err);
        end
        mem_ack = 1'b1; mem_rdata = 32'h55;       // stray late ack
        tick();
        mem_ack = 1'b0;
        n_tests++;
        if (data_ack !== 1'b0 || inst_ack !== 1'b0 || data_rdata !== 32'd0 || mem_stb !== 1'b0) begin
            n_fail++; $display("FAIL to_stray_ack: dack=%b iack=%b rdata=%h stb=%b want 0 0 0 0",
                               data_ack, inst_ack, data_rdata, mem_stb);
        end
        tick();
    endtask

    task automatic test_coincide();
        data_stb = 1'b1; data_addr = 32'h60;
        tick();                                   // grant edge
        data_stb = 1'b0;
        tick(); tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h66666666;
        tick();                                   // expiry edge with ack
        mem_ack = 1'b0;
        n_tests++;
        if (data_ack !== 1'b1 || data_err !== 1'b0 || data_rdata !== 32'h66666666) begin
            n_fail++; $display("FAIL coincide: ack=%b err=%b rdata=%h want 1 0 66666666", data_ack, data_err, data_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        data_stb = 1'b1; data_addr = 32'h70; data_wdata = 32'h77; data_wr_en = 1'b1; data_wr_mask = 4'h3;
        tick();                                   // grant edge
        data_stb = 1'b0;
        n_tests++;
        if (mem_stb !== 1'b1 || mem_wr_en !== 1'b1 || mem_wr_mask !== 4'h3) begin
            n_fail++; $display("FAIL rmid_issue: stb=%b wr_en=%b mask=%h want 1 1 3", mem_stb, mem_wr_en, mem_wr_mask);
        end
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (mem_stb !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wr_en !== 1'b0 ||
            mem_wr_mask !== 4'd0 || data_ack !== 1'b0 || data_rdata !== 32'd0 || inst_rdata !== 32'd0) begin
            n_fail++; $display("FAIL rmid_outputs: stb=%b addr=%h wdata=%h wr_en=%b mask=%h dack=%b drd=%h ird=%h want all 0",
                               mem_stb, mem_addr, mem_wdata, mem_wr_en, mem_wr_mask, data_ack, data_rdata, inst_rdata);
        end
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h99;
        tick();
        mem_ack = 1'b0;
        n_tests++;
        if (data_ack !== 1'b0 || data_rdata !== 32'd0 || mem_stb !== 1'b0) begin
            n_fail++; $display("FAIL rmid_late_ack: ack=%b rdata=%h stb=%b want 0 0 0", data_ack, data_rdata, mem_stb);
        end
        inst_stb = 1'b1; inst_addr = 32'h80;
        tick();
        inst_stb = 1'b0;
        n_tests++;
        if (mem_stb !== 1'b1 || mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL rmid_next_issue: stb=%b addr=%h want 1 00000080", mem_stb, mem_addr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h88;
        tick();
        mem_ack = 1'b0;
        n_tests++;
        if (inst_ack !== 1'b1 || inst_err !== 1'b0 || inst_rdata !== 32'h88) begin
            n_fail++; $display("FAIL rmid_next_ack: ack=%b err=%b rdata=%h want 1 0 00000088", inst_ack, inst_err, inst_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_mid_grant();
        test_timeout();
        test_coincide();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/asrv32_mem_arbiter.md
ASRV32_MEM_ARBITER -- requirements
Module: asrv32_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of grant-cycle edges without i_mem_ack before an error response; legal range 2..255.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have instruction-port inputs: i_inst_stb (1 bit, request pulse) and i_inst_addr (32 bits).
REQ-005 SHALL have instruction-port outputs: o_inst_ack (1 bit), o_inst_rdata (32 bits) and o_inst_err (1 bit).
REQ-006 SHALL have data-port inputs: i_data_stb (1), i_data_addr (32), i_data_wdata (32), i_data_wr_en (1) and i_data_wr_mask (4).
REQ-007 SHALL have data-port outputs: o_data_ack (1), o_data_rdata (32) and o_data_err (1).
REQ-008 SHALL have memory-port outputs: o_mem_stb (1), o_mem_addr (32), o_mem_wdata (32), o_mem_wr_en (1) and o_mem_wr_mask (4).
REQ-009 SHALL have memory-port inputs: i_mem_ack (1) and i_mem_rdata (32); these connect to a single-port RAM with a stb/ack handshake and variable latency.

Function
REQ-010 SHALL share one memory port between the instruction and data requesters, with one transaction outstanding at a time.
REQ-011 SHALL use FSM states IDLE, GRANT_INST and GRANT_DATA.
REQ-012 SHALL define a port's request as its i_*_stb OR its pending flag.
REQ-013 SHALL, in IDLE with at least one request, move at the next edge to GRANT of the winning port, register that port's address/wdata/wr_en/wr_mask onto the memory port, and drive o_mem_stb high for exactly that one following cycle.
REQ-014 SHALL arbitrate round-robin: with both ports requesting, the port not granted last wins; last-grant resets to data, so instruction wins the first tie.
REQ-015 SHALL latch a non-granted or mid-grant i_*_stb into that port's pending register (instruction: addr; data: addr/wdata/wr_en/wr_mask) and set its pending flag; the flag clears when that port is granted.
REQ-016 SHALL ignore an i_*_stb that arrives while the same port already has a pending request or is currently granted, leaving the held request unchanged.
REQ-017 SHALL hold o_mem_addr/wdata/wr_en/wr_mask stable for the whole grant; the instruction grant drives wr_en=0 and wr_mask=0.
REQ-018 SHALL, in GRANT_x with i_mem_ack=1 at an edge, register i_mem_rdata into o_x_rdata, pulse o_x_ack high with o_x_err=0 for one cycle, and return to IDLE.
REQ-019 SHALL clear a timeout counter on entry to GRANT and increment it at each grant edge without ack.
REQ-020 SHALL, at an edge where the counter equals TIMEOUT_CYCLES-1 and i_mem_ack=0, pulse o_x_ack and o_x_err high for one cycle, set o_x_rdata=0, and return to IDLE.
REQ-021 SHALL give the ack precedence when ack and timeout coincide on the same edge (normal response, err=0).
REQ-022 SHALL ignore i_mem_ack while in IDLE, including late acks after a timeout.
REQ-023 SHALL keep o_x_rdata holding its last value between acks, and keep o_*_ack/o_*_err low except during their one-cycle pulses.
REQ-024 SHALL give minimum latency with a 1-cycle memory as: stb sampled at E0, o_mem_stb high E0..E1, ack sampled at E2, o_x_ack high E2..E3; a new grant may start from IDLE at E3.

Reset
REQ-025 SHALL, with i_rst=1 at an edge, set state IDLE, clear both pending flags and the counter, set last-grant to data, and set o_mem_stb, o_mem_wr_en, o_*_ack and o_*_err to 0 and all address/data/mask/rdata outputs to 0.
REQ-026 SHALL abandon any in-flight transaction on reset mid-grant with no ack to the requester; a memory ack arriving after reset is ignored per REQ-022.

Verification
REQ-027 Single read: i_inst_stb with addr 0x10 at E0, 1-cycle memory returning 0xDEADBEEF -> o_mem_stb one cycle, o_inst_ack high E2..E3, o_inst_rdata=0xDEADBEEF, o_inst_err=0.
REQ-028 Simultaneous request: both stb at E0 after reset (data write 0x20, wdata 0xA5A5A5A5, mask 0xF) -> instruction served first, data write issued next from its pending register with wdata/mask unchanged; next tie -> data wins.
REQ-029 Mid-grant request: data stb at E1 while GRANT_INST -> pending set, data granted immediately after the instruction ack, exactly one data o_mem_stb.
REQ-030 Timeout: TIMEOUT_CYCLES=4, memory never acks -> o_data_ack=1 and o_data_err=1 and o_data_rdata=0 four edges after the grant edge; a later stray i_mem_ack is ignored.
REQ-031 Ack/timeout coincidence: ack on the expiry edge -> err=0 and rdata=i_mem_rdata.
REQ-032 Reset mid-grant: i_rst during GRANT_DATA -> all outputs 0, no o_data_ack, following memory ack ignored, next inst stb served normally.
